// File: rtl/garota_reset_seq_pkg.sv
// Shared types and constants for the GAROTA violation reset sequencer.
package garota_reset_seq_pkg;

  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_VEC = 2'd2
  } state_t;

  localparam int CAUSE_W       = 5;
  localparam int CAUSE_UART    = 0;
  localparam int CAUSE_TIMER   = 1;
  localparam int CAUSE_IRQ_TCB = 2;
  localparam int CAUSE_NO_IDIS = 3;
  localparam int CAUSE_TIMEOUT = 4;

  localparam addr_t RESET_HANDLER_DFLT = 16'h0000;
  localparam addr_t TCB_BASE_DFLT      = 16'hA000;
  localparam addr_t TCB_SIZE_DFLT      = 16'h4000;
  localparam addr_t CAUSE_ADDR         = 16'h0190;
  localparam addr_t WAIT_MAX_DFLT      = 16'h0100;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/garota_reset_seq_addr_in_range.sv
// Combinational base/size window check; the upper bound is formed in 17 bits
// so a region ending at 16'hFFFF does not wrap to zero.
module garota_reset_seq_addr_in_range
  import garota_reset_seq_pkg::*;
#(
  parameter addr_t BASE = TCB_BASE_DFLT,
  parameter addr_t SIZE = TCB_SIZE_DFLT
) (
  input  addr_t addr,
  output logic  hit
);

  localparam logic [16:0] LO = {1'b0, BASE};
  localparam logic [16:0] HI = {1'b0, BASE} + {1'b0, SIZE} - 17'd1;

  assign hit = ({1'b0, addr} >= LO) && ({1'b0, addr} <= HI);

endmodule

// File: rtl/garota_reset_seq.sv
// Stretches GAROTA monitor violations into a fixed CPU reset pulse, checks re-entry
// at the reset handler, and keeps a W1C sticky cause vector plus a saturating count.
module garota_reset_seq
  import garota_reset_seq_pkg::*;
#(
  parameter addr_t RESET_HANDLER = RESET_HANDLER_DFLT,
  parameter addr_t TCB_BASE      = TCB_BASE_DFLT,
  parameter addr_t TCB_SIZE      = TCB_SIZE_DFLT,
  parameter addr_t CLEAR_ADDR    = CAUSE_ADDR,
  parameter int    HOLD_CYCLES   = 8,
  parameter addr_t WAIT_MAX      = WAIT_MAX_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           viol,
  input  logic [15:0]          pc,
  input  logic                 data_wr,
  input  logic [15:0]          data_addr,
  input  logic [15:0]          data_in,
  output logic                 cpu_rst,
  output logic [CAUSE_W-1:0]   cause,
  output logic [7:0]           viol_cnt,
  output logic                 busy
);

  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = WAIT_MAX - 16'd1;

  state_t             state, state_n;
  logic [7:0]         hold_cnt, hold_cnt_n;
  logic [15:0]        wait_cnt, wait_cnt_n;
  logic [CAUSE_W-1:0] cause_n, set_bits, clr_mask;
  logic [7:0]         viol_cnt_n;
  logic               inc, pc_in_tcb, clr;
  logic               unused_data_in;

  assign unused_data_in = ^data_in[14:5];

  garota_reset_seq_addr_in_range #(
    .BASE (TCB_BASE),
    .SIZE (TCB_SIZE)
  ) u_tcb_range (
    .addr (pc),
    .hit  (pc_in_tcb)
  );

  // Software clear is honoured only from trusted code and only while idle.
  assign clr      = (state == ST_IDLE) && data_wr && (data_addr == CLEAR_ADDR) && pc_in_tcb;
  assign clr_mask = clr ? data_in[CAUSE_W-1:0] : '0;

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    wait_cnt_n = wait_cnt;
    set_bits   = {1'b0, viol};
    inc        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (viol != 4'd0) begin
          state_n    = ST_HOLD;
          hold_cnt_n = 8'd0;
          inc        = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n    = ST_WAIT_VEC;
          wait_cnt_n = 16'd0;
        end else begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end
      ST_WAIT_VEC: begin
        if (viol != 4'd0) begin
          state_n    = ST_HOLD;
          hold_cnt_n = 8'd0;
          inc        = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          state_n = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n                 = ST_HOLD;
          hold_cnt_n              = 8'd0;
          inc                     = 1'b1;
          set_bits[CAUSE_TIMEOUT] = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + 16'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // New violations win over a simultaneous clear of the same bits and of the count.
    cause_n = (cause & ~clr_mask) | set_bits;
    if (inc) begin
      viol_cnt_n = sat_inc8(viol_cnt);
    end else if (clr && data_in[15]) begin
      viol_cnt_n = 8'd0;
    end else begin
      viol_cnt_n = viol_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= 8'd0;
      wait_cnt <= 16'd0;
      cause    <= '0;
      viol_cnt <= 8'd0;
      cpu_rst  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
      wait_cnt <= wait_cnt_n;
      cause    <= cause_n;
      viol_cnt <= viol_cnt_n;
      cpu_rst  <= (state_n == ST_HOLD);
      busy     <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_garota_reset_seq.sv
// Bench for garota_reset_seq: directed scenarios plus random traffic, all checked
// cycle by cycle against a pulse/timeout reference model.
module tb_garota_reset_seq;

  localparam int HOLD      = 8;
  localparam int WAIT_MAX  = 256;
  localparam int TCB_LO    = 'hA000;
  localparam int TCB_HI    = 'hA000 + 'h4000 - 1;
  localparam logic [15:0] CLR_ADDR = 16'h0190;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  viol;
  logic [15:0] pc, data_addr, data_in;
  logic        data_wr;
  logic        cpu_rst, busy;
  logic [4:0]  cause;
  logic [7:0]  viol_cnt;

  int checks   = 0;
  int failures = 0;
  int rst_hi   = 0;

  // reference model: remaining pulse cycles, vector-wait progress, sticky status
  int         m_hold_left = 0;
  bit         m_in_wait   = 1'b0;
  int         m_waited    = 0;
  logic [4:0] m_cause     = '0;
  int         m_cnt       = 0;

  garota_reset_seq dut (
    .clk       (clk),
    .rst       (rst),
    .viol      (viol),
    .pc        (pc),
    .data_wr   (data_wr),
    .data_addr (data_addr),
    .data_in   (data_in),
    .cpu_rst   (cpu_rst),
    .cause     (cause),
    .viol_cnt  (viol_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic bump();
    m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
  endtask

  task automatic model_update();
    bit         idle, clr;
    int         p;
    logic [4:0] mask;
    if (rst) begin
      m_hold_left = 0; m_in_wait = 1'b0; m_waited = 0; m_cause = '0; m_cnt = 0;
      return;
    end
    p    = 32'(pc);
    idle = (m_hold_left == 0) && !m_in_wait;
    clr  = idle && data_wr && (data_addr == CLR_ADDR) && (p >= TCB_LO) && (p <= TCB_HI);
    mask = clr ? data_in[4:0] : 5'd0;
    m_cause = (m_cause & ~mask) | {1'b0, viol};
    if (idle) begin
      if (viol != 4'd0) begin
        m_hold_left = HOLD;
        bump();
      end else if (clr && data_in[15]) begin
        m_cnt = 0;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_in_wait = 1'b1;
        m_waited  = 0;
      end
    end else begin
      if (viol != 4'd0) begin
        m_in_wait = 1'b0; m_hold_left = HOLD; bump();
      end else if (pc == 16'h0000) begin
        m_in_wait = 1'b0;
      end else if (m_waited == WAIT_MAX - 1) begin
        m_in_wait = 1'b0; m_hold_left = HOLD; m_cause[4] = 1'b1; bump();
      end else begin
        m_waited++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("cpu_rst",  32'(cpu_rst),  32'(m_hold_left > 0));
    check("busy",     32'(busy),     32'((m_hold_left > 0) || m_in_wait));
    check("cause",    32'(cause),    32'(m_cause));
    check("viol_cnt", 32'(viol_cnt), 32'(m_cnt));
    if (cpu_rst) rst_hi++;
  endtask

  task automatic cyc(input logic [3:0] v, input logic [15:0] p, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    viol = v; pc = p; data_wr = w; data_addr = a; data_in = d;
    step();
  endtask

  task automatic idle_cycles(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) cyc(4'd0, p, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_cycles(n, 16'h0000);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; viol = '0; pc = '0; data_wr = 1'b0; data_addr = '0; data_in = '0;

    // 1: reset then quiet
    do_reset(2);
    check("t1_rst_cpu_rst", 32'(cpu_rst), 32'd0);
    check("t1_rst_cause",   32'(cause),   32'd0);
    idle_cycles(50, 16'h0000);
    check("t1_cnt",  32'(viol_cnt), 32'd0);
    check("t1_busy", 32'(busy),     32'd0);

    // 2: single violation, clean re-entry
    rst_hi = 0;
    cyc(4'b0001, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle_cycles(12, 16'h0000);
    check("t2_pulse_len", 32'(rst_hi), 32'd8);
    check("t2_cause",     32'(cause),  32'h01);
    check("t2_cnt",       32'(viol_cnt), 32'd1);
    check("t2_busy",      32'(busy),   32'd0);

    // 3: second violation inside HOLD neither restarts nor counts
    do_reset(1);
    rst_hi = 0;
    cyc(4'b0100, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle_cycles(2, 16'h0000);
    cyc(4'b1000, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle_cycles(12, 16'h0000);
    check("t3_pulse_len", 32'(rst_hi), 32'd8);
    check("t3_cause",     32'(cause),  32'h0C);
    check("t3_cnt",       32'(viol_cnt), 32'd1);

    // 4: vector timeout
    do_reset(1);
    cyc(4'b0001, 16'hC000, 1'b0, 16'h0, 16'h0);
    idle_cycles(HOLD + WAIT_MAX - 1, 16'hC000);
    check("t4_last_wait_rst",  32'(cpu_rst), 32'd0);
    check("t4_last_wait_busy", 32'(busy),    32'd1);
    idle_cycles(1, 16'hC000);
    check("t4_rehold",   32'(cpu_rst),  32'd1);
    check("t4_cause",    32'(cause),    32'h11);
    check("t4_cnt",      32'(viol_cnt), 32'd2);
    idle_cycles(12, 16'h0000);
    check("t4_exit_busy", 32'(busy), 32'd0);

    // reset in the middle of HOLD
    cyc(4'b0010, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle_cycles(3, 16'h0000);
    do_reset(1);
    check("mid_rst_cpu_rst", 32'(cpu_rst),  32'd0);
    check("mid_rst_cnt",     32'(viol_cnt), 32'd0);

    // 5: W1C clear, trusted-region boundaries
    cyc(4'b0011, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle_cycles(12, 16'h0000);
    cyc(4'd0, 16'hA010, 1'b1, 16'h0192, 16'h801F);
    check("t5_wrong_addr", 32'(cause), 32'h03);
    cyc(4'd0, 16'hA010, 1'b1, CLR_ADDR, 16'h8001);
    check("t5_clr_cause", 32'(cause),    32'h02);
    check("t5_clr_cnt",   32'(viol_cnt), 32'd0);
    cyc(4'd0, 16'h4000, 1'b1, CLR_ADDR, 16'h8002);
    check("t5_outside", 32'(cause), 32'h02);
    cyc(4'd0, 16'hE000, 1'b1, CLR_ADDR, 16'h0002);
    check("t5_above_tcb", 32'(cause), 32'h02);
    cyc(4'd0, 16'h9FFF, 1'b1, CLR_ADDR, 16'h0002);
    check("t5_below_tcb", 32'(cause), 32'h02);
    cyc(4'd0, 16'hDFFF, 1'b1, CLR_ADDR, 16'h0002);
    check("t5_top_of_tcb", 32'(cause), 32'h00);

    // 6: saturation, then set-wins
    for (int i = 0; i < 300; i++) begin
      cyc(4'b0001, 16'h0000, 1'b0, 16'h0, 16'h0);
      idle_cycles(10, 16'h0000);
    end
    check("t6_sat", 32'(viol_cnt), 32'hFF);
    cyc(4'b0110, 16'h0000, 1'b0, 16'h0, 16'h0);
    idle_cycles(12, 16'h0000);
    cyc(4'd0, 16'hA010, 1'b1, CLR_ADDR, 16'h8000);
    check("t6_cnt_clr", 32'(viol_cnt), 32'd0);
    cyc(4'b0001, 16'hA010, 1'b1, CLR_ADDR, 16'h001F);
    check("t6_setwin_cause", 32'(cause),    32'h01);
    check("t6_setwin_cnt",   32'(viol_cnt), 32'd1);
    idle_cycles(12, 16'h0000);

    // random traffic
    for (int i = 0; i < 6000; i++) begin
      logic [3:0]  v;
      logic [15:0] p, a, d;
      logic        w;
      int          r;
      v = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      r = $urandom_range(0, 99);
      p = (r < 2) ? 16'h0000 : (r < 40) ? 16'($urandom_range(TCB_LO, TCB_HI))
                                        : 16'($urandom);
      w = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 1) == 0) ? CLR_ADDR : 16'($urandom);
      d = 16'($urandom);
      if (v != 4'd0) d[15] = 1'b0;
      rst = ($urandom_range(0, 999) == 0);
      cyc(v, p, w, a, d);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
